// File: rtl/instr_fetch.sv
// Instruction fetch unit: assembles big-endian 32-bit words from a byte-wide
// program RAM and hands them to the decoder over a valid/ready handshake.
module instr_fetch #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              ram_rd,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [7:0]        ram_rdata,
  output logic [31:0]       ir,
  output logic [ADDR_W-1:0] ir_pc,
  output logic              ir_valid,
  input  logic              ir_ready,
  input  logic              jmp,
  input  logic [23:0]       jmp_offset,
  input  logic              halt,
  output logic              halted
);

  localparam int unsigned EXT_W = (ADDR_W > 26) ? ADDR_W : 26;

  localparam logic [1:0] ST_FETCH  = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;
  localparam logic [1:0] ST_HALTED = 2'd3;

  logic [1:0]        r_state, w_state;
  logic [1:0]        r_k, w_k;
  logic [ADDR_W-1:0] r_pc, w_pc;
  logic [23:0]       r_shift, w_shift;
  logic              r_pend, w_pend;
  logic              r_ram_rd, w_ram_rd;
  logic [ADDR_W-1:0] r_ram_addr, w_ram_addr;
  logic [31:0]       r_ir, w_ir;
  logic [ADDR_W-1:0] r_ir_pc, w_ir_pc;
  logic              r_ir_valid, w_ir_valid;
  logic              r_halted, w_halted;

  logic [EXT_W-1:0]  w_off_ext;
  logic [ADDR_W-1:0] w_jmp_tgt;

  // Offset is in instructions; scale to bytes and wrap to the address width.
  assign w_off_ext = EXT_W'($signed({jmp_offset, 2'b00}));
  assign w_jmp_tgt = r_ir_pc + w_off_ext[ADDR_W-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_FETCH;
      r_k        <= 2'd0;
      r_pc       <= ADDR_W'(RESET_PC);
      r_shift    <= 24'd0;
      r_pend     <= 1'b0;
      r_ram_rd   <= 1'b0;
      r_ram_addr <= '0;
      r_ir       <= 32'd0;
      r_ir_pc    <= '0;
      r_ir_valid <= 1'b0;
      r_halted   <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_k        <= w_k;
      r_pc       <= w_pc;
      r_shift    <= w_shift;
      r_pend     <= w_pend;
      r_ram_rd   <= w_ram_rd;
      r_ram_addr <= w_ram_addr;
      r_ir       <= w_ir;
      r_ir_pc    <= w_ir_pc;
      r_ir_valid <= w_ir_valid;
      r_halted   <= w_halted;
    end
  end

  // r_k counts bytes already requested; r_pend marks ram_rdata valid this cycle.
  always_comb begin
    w_state    = r_state;
    w_k        = r_k;
    w_pc       = r_pc;
    w_shift    = r_pend ? {r_shift[15:0], ram_rdata} : r_shift;
    w_pend     = r_ram_rd;
    w_ram_rd   = 1'b0;
    w_ram_addr = r_ram_addr;
    w_ir       = r_ir;
    w_ir_pc    = r_ir_pc;
    w_ir_valid = r_ir_valid;
    w_halted   = r_halted;

    if (r_state == ST_HALTED) begin
      w_pend = 1'b0;
    end else if (halt) begin
      w_state    = ST_HALTED;
      w_ir_valid = 1'b0;
      w_halted   = 1'b1;
      w_pend     = 1'b0;
    end else if (jmp) begin
      // Redirect immediately; any byte still in flight is dropped via w_pend.
      w_pc       = w_jmp_tgt;
      w_ir_valid = 1'b0;
      w_pend     = 1'b0;
      w_ram_rd   = 1'b1;
      w_ram_addr = w_jmp_tgt;
      w_k        = 2'd1;
      w_state    = ST_FETCH;
    end else begin
      case (r_state)
        ST_FETCH: begin
          w_ram_rd   = 1'b1;
          w_ram_addr = r_pc + ADDR_W'(r_k);
          w_k        = r_k + 2'd1;
          if (r_k == 2'd3) w_state = ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!r_ram_rd) begin
            w_ir       = {r_shift, ram_rdata};
            w_ir_pc    = r_pc;
            w_ir_valid = 1'b1;
            w_state    = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (r_ir_valid && ir_ready) begin
            w_pc       = r_pc + ADDR_W'(4);
            w_ir_valid = 1'b0;
            w_ram_rd   = 1'b1;
            w_ram_addr = r_pc + ADDR_W'(4);
            w_k        = 2'd1;
            w_state    = ST_FETCH;
          end
        end
        default: ;
      endcase
    end
  end

  assign ram_rd   = r_ram_rd;
  assign ram_addr = r_ram_addr;
  assign ir       = r_ir;
  assign ir_pc    = r_ir_pc;
  assign ir_valid = r_ir_valid;
  assign halted   = r_halted;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: byte RAM model, cycle-level reference model and
// directed scenarios with hand-computed expectations.
module tb_instr_fetch;

  logic        clk;
  logic        rst;
  logic        ram_rd;
  logic [15:0] ram_addr;
  logic [7:0]  ram_rdata;
  logic [31:0] ir;
  logic [15:0] ir_pc;
  logic        ir_valid;
  logic        ir_ready;
  logic        jmp;
  logic [23:0] jmp_offset;
  logic        halt;
  logic        halted;

  int n_vec = 0;
  int n_err = 0;
  logic cmp_en = 1'b0;

  logic [7:0] mem [0:65535];

  instr_fetch #(.ADDR_W(16), .RESET_PC(0)) dut (
    .clk(clk), .rst(rst),
    .ram_rd(ram_rd), .ram_addr(ram_addr), .ram_rdata(ram_rdata),
    .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid), .ir_ready(ir_ready),
    .jmp(jmp), .jmp_offset(jmp_offset), .halt(halt), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program RAM: data for a request appears in the following cycle.
  always @(posedge clk) ram_rdata <= ram_rd ? mem[ram_addr] : 8'hEE;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [15:0] a);
    return {mem[a], mem[a + 16'd1], mem[a + 16'd2], mem[a + 16'd3]};
  endfunction

  // Reference model: phase = cycles since the fetch of m_pc began
  // (0..3 requesting bytes, 4 draining, 5 presenting), -1 idle after reset.
  int          m_phase;
  logic [15:0] m_pc, m_addr, m_ir_pc;
  logic [31:0] m_ir;
  logic        m_valid, m_halted, m_rd;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_phase = -1; m_pc = 16'h0000; m_addr = 16'h0000; m_ir = 32'h0;
      m_ir_pc = 16'h0000; m_valid = 1'b0; m_halted = 1'b0; m_rd = 1'b0;
    end else if (!m_halted) begin
      if (halt) begin
        m_halted = 1'b1;
        m_valid  = 1'b0;
      end else if (jmp) begin
        m_pc    = m_ir_pc + 16'(int'($signed(jmp_offset)) * 4);
        m_phase = 0;
        m_valid = 1'b0;
      end else if (m_valid && ir_ready) begin
        m_pc    = m_pc + 16'd4;
        m_phase = 0;
        m_valid = 1'b0;
      end else if (m_phase < 5) begin
        m_phase++;
        if (m_phase == 5) begin
          m_valid = 1'b1;
          m_ir    = word_at(m_pc);
          m_ir_pc = m_pc;
        end
      end
      m_rd = !m_halted && (m_phase >= 0) && (m_phase <= 3);
      if (m_rd) m_addr = m_pc + 16'(m_phase);
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_ram_rd", 32'(ram_rd), 32'(m_rd));
      chk("m_ram_addr", 32'(ram_addr), 32'(m_addr));
      chk("m_ir_valid", 32'(ir_valid), 32'(m_valid));
      chk("m_halted", 32'(halted), 32'(m_halted));
      if (m_valid) begin
        chk("m_ir", ir, m_ir);
        chk("m_ir_pc", 32'(ir_pc), 32'(m_ir_pc));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'(i * 37 + 11);
    mem[16'h0000] = 8'h01; mem[16'h0001] = 8'h2A; mem[16'h0002] = 8'h00; mem[16'h0003] = 8'h00;
    mem[16'h0004] = 8'h11; mem[16'h0005] = 8'h22; mem[16'h0006] = 8'h33; mem[16'h0007] = 8'h44;
    mem[16'h0008] = 8'h55; mem[16'h0009] = 8'h66; mem[16'h000A] = 8'h77; mem[16'h000B] = 8'h88;
    mem[16'h0010] = 8'hA1; mem[16'h0011] = 8'hB2; mem[16'h0012] = 8'hC3; mem[16'h0013] = 8'hD4;
    mem[16'h001C] = 8'hDE; mem[16'h001D] = 8'hAD; mem[16'h001E] = 8'hBE; mem[16'h001F] = 8'hEF;
    mem[16'hFFFC] = 8'hCA; mem[16'hFFFD] = 8'hFE; mem[16'hFFFE] = 8'hF0; mem[16'hFFFF] = 8'h0D;

    rst = 1'b0; ir_ready = 1'b0; jmp = 1'b0; jmp_offset = 24'd0; halt = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ram_rd", 32'(ram_rd), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_ir", ir, 32'd0);
    chk("rst_ir_pc", 32'(ir_pc), 32'd0);
    chk("rst_ir_valid", 32'(ir_valid), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    cmp_en = 1'b1;
    rst = 1'b1;
    ir_ready = 1'b1;

    // First fetch from reset
    tick(); chk("c0_rd", 32'(ram_rd), 32'd1); chk("c0_addr", 32'(ram_addr), 32'h0);
    tick(); chk("c1_addr", 32'(ram_addr), 32'h1);
    tick(); chk("c2_addr", 32'(ram_addr), 32'h2);
    tick(); chk("c3_addr", 32'(ram_addr), 32'h3);
    tick(); chk("c4_rd", 32'(ram_rd), 32'd0);
    tick(); chk("c5_valid", 32'(ir_valid), 32'd1); chk("c5_ir", ir, 32'h012A0000);
    chk("c5_ir_pc", 32'(ir_pc), 32'h0);
    tick(); chk("c6_rd", 32'(ram_rd), 32'd1); chk("c6_addr", 32'(ram_addr), 32'h4);
    ir_ready = 1'b0;

    // Backpressure for three presented cycles
    repeat (5) tick();
    chk("bp0_ir", ir, 32'h11223344); chk("bp0_ir_pc", 32'(ir_pc), 32'h4);
    tick(); chk("bp1_ir", ir, 32'h11223344); chk("bp1_rd", 32'(ram_rd), 32'd0);
    tick(); chk("bp2_ir", ir, 32'h11223344); chk("bp2_rd", 32'(ram_rd), 32'd0);
    chk("bp2_valid", 32'(ir_valid), 32'd1);
    ir_ready = 1'b1;
    tick(); chk("bp_xfer_addr", 32'(ram_addr), 32'h8); chk("bp_xfer_valid", 32'(ir_valid), 32'd0);

    // Jump back by two instructions after 0x0008 is transferred
    repeat (5) tick();
    chk("i8_ir", ir, 32'h55667788); chk("i8_ir_pc", 32'(ir_pc), 32'h8);
    tick(); chk("i8_next_addr", 32'(ram_addr), 32'hC);
    jmp = 1'b1; jmp_offset = 24'hFFFFFE;
    tick(); jmp = 1'b0;
    chk("jb_addr0", 32'(ram_addr), 32'h0); chk("jb_rd", 32'(ram_rd), 32'd1);
    tick(); chk("jb_addr1", 32'(ram_addr), 32'h1);
    tick(); chk("jb_addr2", 32'(ram_addr), 32'h2);
    tick(); chk("jb_addr3", 32'(ram_addr), 32'h3);
    tick();
    tick(); chk("jb_ir_pc", 32'(ir_pc), 32'h0); chk("jb_ir", ir, 32'h012A0000);

    // Jump together with a ready handshake: jump target, no pc+4
    jmp = 1'b1; jmp_offset = 24'd4;
    tick(); jmp = 1'b0;
    chk("jr_addr", 32'(ram_addr), 32'h10); chk("jr_valid", 32'(ir_valid), 32'd0);
    repeat (5) tick();
    chk("i10_ir", ir, 32'hA1B2C3D4); chk("i10_ir_pc", 32'(ir_pc), 32'h10);

    // Jump while the third byte of 0x0014 is being requested
    tick(); chk("mf_k0", 32'(ram_addr), 32'h14);
    tick();
    tick(); chk("mf_k2", 32'(ram_addr), 32'h16);
    jmp = 1'b1; jmp_offset = 24'd3;
    tick(); jmp = 1'b0;
    chk("mf_tgt", 32'(ram_addr), 32'h1C);
    repeat (5) tick();
    chk("mf_ir", ir, 32'hDEADBEEF); chk("mf_ir_pc", 32'(ir_pc), 32'h1C);

    // Jump to the top of memory, then wrap on the +4 after transfer
    jmp = 1'b1; jmp_offset = 24'hFFFFF8;
    tick(); jmp = 1'b0;
    chk("wr_addr", 32'(ram_addr), 32'hFFFC);
    repeat (5) tick();
    chk("wr_ir", ir, 32'hCAFEF00D); chk("wr_ir_pc", 32'(ir_pc), 32'hFFFC);
    tick(); chk("wr_next_addr", 32'(ram_addr), 32'h0); chk("wr_next_rd", 32'(ram_rd), 32'd1);
    repeat (5) tick();
    chk("wr_ir2", ir, 32'h012A0000); chk("wr_ir2_pc", 32'(ir_pc), 32'h0);

    // Halt and jump in the same cycle
    tick(); chk("h_pre_addr", 32'(ram_addr), 32'h4);
    halt = 1'b1; jmp = 1'b1; jmp_offset = 24'd5;
    tick(); halt = 1'b0; jmp = 1'b0;
    chk("h_halted", 32'(halted), 32'd1); chk("h_rd", 32'(ram_rd), 32'd0);
    chk("h_valid", 32'(ir_valid), 32'd0);
    tick(); jmp = 1'b1;
    tick(); jmp = 1'b0;
    tick(); chk("h_sticky", 32'(halted), 32'd1); chk("h_rd_sticky", 32'(ram_rd), 32'd0);

    // Leave halt through reset, then reset asynchronously mid-fetch
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tick(); chk("r2_addr0", 32'(ram_addr), 32'h0);
    tick();
    tick();
    tick(); chk("r2_rd3", 32'(ram_rd), 32'd1); chk("r2_addr3", 32'(ram_addr), 32'h3);
    #2 rst = 1'b0;
    #1;
    chk("ar_rd", 32'(ram_rd), 32'd0); chk("ar_valid", 32'(ir_valid), 32'd0);
    chk("ar_halted", 32'(halted), 32'd0); chk("ar_addr", 32'(ram_addr), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick(); chk("ar_re_rd", 32'(ram_rd), 32'd1); chk("ar_re_addr", 32'(ram_addr), 32'h0);
    repeat (5) tick();
    chk("ar_ir", ir, 32'h012A0000); chk("ar_ir_pc", 32'(ir_pc), 32'h0);
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
